// File: rtl/mhsa_pkg.sv
// Shared types and constants for the MHSA weight path.
package mhsa_pkg;

  localparam int unsigned MHSA_WIDTH         = 64;
  localparam int unsigned MHSA_WORDS_PER_ROW = 16;

  typedef enum logic {IDLE, BURST} wk_state_t;

  typedef struct packed {
    logic                  write_en;
    logic [31:0]           addr;
    logic [MHSA_WIDTH-1:0] data;
  } mem_cmd_t;

endpackage

// File: rtl/wk_out_fifo.sv
// Synchronous FIFO for fetched weight words; each entry carries its end-of-row flag.
module wk_out_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    count
);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = pop_ready && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= {push_last, push_data};
  end

  // Storage is not reset, so the head is masked while empty.
  assign out_valid             = (r_count != '0);
  assign {out_last, out_data}  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count                 = r_count;

endmodule

// File: rtl/wk_fetch_ctrl.sv
// Row-fetch sequencer and host-write arbiter for the single-port key-weight memory.
module wk_fetch_ctrl
  import mhsa_pkg::*;
#(
  parameter int unsigned WIDTH         = MHSA_WIDTH,
  parameter int unsigned LENGTH        = 4096,
  parameter int unsigned WORDS_PER_ROW = MHSA_WORDS_PER_ROW,
  parameter int unsigned ROWS          = LENGTH / WORDS_PER_ROW,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_req_valid,
  output logic                    fetch_req_ready,
  input  logic [$clog2(ROWS)-1:0] fetch_row,
  input  logic                    host_wr_valid,
  output logic                    host_wr_ready,
  input  logic [31:0]             host_wr_addr,
  input  logic [WIDTH-1:0]        host_wr_data,
  output logic                    mem_write_en,
  output logic [31:0]             mem_addr,
  output logic [WIDTH-1:0]        mem_data_in,
  input  logic [WIDTH-1:0]        mem_data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_ROW);
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);

  wk_state_t        r_state, w_state_next;
  mem_cmd_t         r_cmd, w_cmd_next;
  logic             r_last_fetch, w_last_fetch_next;  // 1: fetch won the previous grant
  logic             r_err, w_err_next;
  logic [31:0]      r_base, w_base_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_vld, r_vld_last;
  logic [FC_W-1:0]  w_fifo_count;
  logic [FC_W:0]    w_used;
  logic             w_idle, w_fetch_grant, w_host_grant, w_issue, w_issue_last, w_host_ok;

  // Readies are combinational, so they are masked while reset is held.
  assign w_idle        = rst_n && (r_state == IDLE);
  assign w_fetch_grant = w_idle && fetch_req_valid && (!host_wr_valid || !r_last_fetch);
  assign w_host_grant  = w_idle && host_wr_valid && (!fetch_req_valid || r_last_fetch);
  assign w_host_ok     = (host_wr_addr < LENGTH);

  // Credit: FIFO occupancy plus reads still in the memory pipe.
  assign w_used       = (FC_W+1)'(w_fifo_count) + (FC_W+1)'(r_vld[0]) + (FC_W+1)'(r_vld[1]);
  assign w_issue      = (r_state == BURST) && (w_used < (FC_W+1)'(FIFO_DEPTH));
  assign w_issue_last = w_issue && (r_cnt == CNT_W'(WORDS_PER_ROW - 1));

  always_comb begin
    w_state_next        = r_state;
    w_cmd_next          = r_cmd;
    w_cmd_next.write_en = 1'b0;
    w_last_fetch_next   = r_last_fetch;
    w_err_next          = r_err;
    w_base_next         = r_base;
    w_cnt_next          = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_fetch_grant) begin
          w_base_next       = 32'(fetch_row) * WORDS_PER_ROW;
          w_cnt_next        = '0;
          w_last_fetch_next = 1'b1;
          w_state_next      = BURST;
        end else if (w_host_grant) begin
          w_last_fetch_next = 1'b0;
          if (w_host_ok) begin
            w_cmd_next.write_en = 1'b1;
            w_cmd_next.addr     = host_wr_addr;
            w_cmd_next.data     = host_wr_data;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      BURST: begin
        if (w_issue) begin
          w_cmd_next.addr = r_base + 32'(r_cnt);
          w_cnt_next      = r_cnt + 1'b1;
          if (w_issue_last) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cmd        <= '0;
      r_last_fetch <= 1'b0;
      r_err        <= 1'b0;
      r_base       <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cmd        <= w_cmd_next;
      r_last_fetch <= w_last_fetch_next;
      r_err        <= w_err_next;
      r_base       <= w_base_next;
      r_cnt        <= w_cnt_next;
    end
  end

  // Stage 0 aligns with mem_addr, stage 1 with mem_data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_vld_last <= '0;
    end else begin
      r_vld      <= {r_vld[0], w_issue};
      r_vld_last <= {r_vld_last[0], w_issue_last};
    end
  end

  wk_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_vld[1]),
    .push_data (mem_data_out),
    .push_last (r_vld_last[1]),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (w_fifo_count)
  );

  assign fetch_req_ready = w_fetch_grant;
  assign host_wr_ready   = w_host_grant;
  assign mem_write_en    = r_cmd.write_en;
  assign mem_addr        = r_cmd.addr;
  assign mem_data_in     = r_cmd.data;
  assign busy            = (r_state != IDLE) || out_valid;
  assign err             = r_err;

endmodule

// File: tb/tb_wk_fetch_ctrl.sv
// Directed bench for wk_fetch_ctrl: memory model plus scoreboard on the weight stream.
module tb_wk_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_req_valid, fetch_req_ready;
  logic [7:0]  fetch_row;
  logic        host_wr_valid, host_wr_ready;
  logic [31:0] host_wr_addr;
  logic [63:0] host_wr_data;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_data_in, mem_data_out;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic        busy, err;

  int n_checks = 0;
  int n_errors = 0;
  int words_seen = 0;

  logic [63:0] exp_mem [4096];
  logic [64:0] exp_q [$];

  wk_fetch_ctrl u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_row       (fetch_row),
    .host_wr_valid   (host_wr_valid),
    .host_wr_ready   (host_wr_ready),
    .host_wr_addr    (host_wr_addr),
    .host_wr_data    (host_wr_data),
    .mem_write_en    (mem_write_en),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .err             (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pat(input int unsigned a);
    return {16'hC0DE, a[15:0], ~a};
  endfunction

  // Single-port memory: registered read, write on write_en.
  initial begin
    logic [63:0] tb_mem [4096];
    for (int a = 0; a < 4096; a++) tb_mem[a] = pat(a);
    mem_data_out = '0;
    forever begin
      @(posedge clk);
      if (mem_write_en) tb_mem[mem_addr[11:0]] <= mem_data_in;
      mem_data_out <= tb_mem[mem_addr[11:0]];
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-stability.
  initial begin
    logic        hold;
    logic [64:0] held;
    logic [64:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 65'(out_valid), 65'd1);
          chk("hold_word", {out_last, out_data}, held);
        end
        if (out_valid && out_ready) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got %h expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("stream_word", {out_last, out_data}, e);
          end
        end
        hold = out_valid && !out_ready;
        held = {out_last, out_data};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_row(input int unsigned row);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), exp_mem[row * 16 + k]});
  endtask

  task automatic host_write(input logic [31:0] a, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    #1;
    while (!host_wr_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("host_grant", 65'(host_wr_ready), 65'd1);
    @(posedge clk);
    #1;
    host_wr_valid = 1'b0;
    chk("host_we", 65'(mem_write_en), (a < 4096) ? 65'd1 : 65'd0);
    if (a < 4096) begin
      chk("host_addr", 65'(mem_addr), 65'(a));
      chk("host_data", 65'(mem_data_in), 65'(d));
      exp_mem[a[11:0]] = d;
    end
  endtask

  task automatic fetch(input int unsigned row);
    int n;
    n = 0;
    @(negedge clk);
    fetch_req_valid = 1'b1;
    fetch_row       = 8'(row);
    #1;
    while (!fetch_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("fetch_grant", 65'(fetch_req_ready), 65'd1);
    if (fetch_req_ready) push_row(row);
    @(posedge clk);
    #1;
    fetch_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", 65'(busy || exp_q.size() != 0), 65'd0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_out_valid"}, 65'(out_valid), 65'd0);
    chk({pfx, "_out_word"}, {out_last, out_data}, 65'd0);
    chk({pfx, "_mem_cmd"}, 65'({mem_write_en, mem_addr, mem_data_in[31:0]}), 65'd0);
    chk({pfx, "_mem_din_hi"}, 65'(mem_data_in[63:32]), 65'd0);
    chk({pfx, "_readies"}, 65'({fetch_req_ready, host_wr_ready}), 65'd0);
    chk({pfx, "_busy_err"}, 65'({busy, err}), 65'd0);
  endtask

  initial begin
    int          kinds [4];
    int          gidx [4];
    int          g, cyc, n, w0;
    logic [15:0] bp;

    for (int a = 0; a < 4096; a++) exp_mem[a] = pat(a);
    rst_n           = 1'b0;
    fetch_req_valid = 1'b0;
    fetch_row       = '0;
    host_wr_valid   = 1'b0;
    host_wr_addr    = '0;
    host_wr_data    = '0;
    out_ready       = 1'b1;
    #3;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held from reset: expect F, H, F, H with burst-length gaps.
    fetch_req_valid = 1'b1;
    fetch_row       = 8'd10;
    host_wr_valid   = 1'b1;
    host_wr_addr    = 32'd2000;
    host_wr_data    = 64'h0123_4567_89AB_CDEF;
    g   = 0;
    cyc = 0;
    while (g < 4 && cyc < 200) begin
      #1;
      chk("arb_one_grant", 65'(fetch_req_ready && host_wr_ready), 65'd0);
      if (fetch_req_ready) begin
        kinds[g] = 1;
        gidx[g]  = cyc;
        g++;
        push_row(int'(fetch_row));
        @(posedge clk);
        #1;
        fetch_row = fetch_row + 8'd1;
      end else if (host_wr_ready) begin
        kinds[g] = 0;
        gidx[g]  = cyc;
        g++;
        exp_mem[host_wr_addr[11:0]] = host_wr_data;
        @(posedge clk);
        #1;
        chk("arb_host_we", 65'(mem_write_en), 65'd1);
        chk("arb_host_addr", 65'(mem_addr), 65'(host_wr_addr));
        chk("arb_host_data", 65'(mem_data_in), 65'(host_wr_data));
        host_wr_addr = host_wr_addr + 32'd1;
        host_wr_data = host_wr_data + 64'd1;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
      cyc++;
    end
    fetch_req_valid = 1'b0;
    host_wr_valid   = 1'b0;
    chk("arb_grant_count", 65'(g), 65'd4);
    if (g == 4) begin
      chk("arb_order", 65'({kinds[0][0], kinds[1][0], kinds[2][0], kinds[3][0]}), 65'b1010);
      chk("arb_gap_fh", 65'(gidx[1] - gidx[0]), 65'd17);
      chk("arb_gap_hf", 65'(gidx[2] - gidx[1]), 65'd1);
      chk("arb_gap_fh2", 65'(gidx[3] - gidx[2]), 65'd17);
    end
    wait_idle();

    // Row 3 word k = k, then a single fetch with latency checks.
    for (int k = 0; k < 16; k++) host_write(32'(48 + k), 64'(k));
    wait_idle();
    fetch(3);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("first_valid_latency", 65'(cyc), 65'd3);
    while (!(out_valid && out_last) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("last_latency", 65'(cyc), 65'd18);
    wait_idle();

    // Write-then-read.
    host_write(32'd17, 64'hDEAD_BEEF_0000_0001);
    fetch(1);
    wait_idle();

    // Out-of-range host write.
    chk("err_clear", 65'(err), 65'd0);
    host_write(32'd4096, 64'hBAD0_BAD0_BAD0_BAD0);
    chk("err_set", 65'(err), 65'd1);
    fetch(0);
    wait_idle();
    chk("err_sticky", 65'(err), 65'd1);

    // Back-pressure on row 255: four reads in flight, then stall.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fetch(255);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_stall_addr", 65'(mem_addr), 65'd4083);
    chk("bp_busy", 65'(busy), 65'd1);
    bp = 16'b1001_0110_0011_1010;
    for (int i = 0; i < 300 && (busy || exp_q.size() != 0); i++) begin
      out_ready = bp[i % 16];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a burst.
    w0 = words_seen;
    fetch(7);
    n = 0;
    while ((words_seen - w0) < 7 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pre_reset_words", 65'(words_seen - w0), 65'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch(2);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
